// File: rtl/button_conditioner.sv
// Push-button conditioner: two-flop synchronizer, counter debounce and a
// per-channel press/hold-repeat FSM producing single-cycle inc/dec commands.
module button_conditioner #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [15:0] REPEAT_DELAY    = 16'd25000,
  parameter logic [15:0] REPEAT_PERIOD   = 16'd10000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic btn_inc_raw,
  input  logic btn_dec_raw,
  output logic inc_pulse,
  output logic dec_pulse,
  output logic inc_level,
  output logic dec_level
);

  typedef enum logic [1:0] {
    RELEASED,
    HELD_DELAY,
    HELD_REPEAT
  } state_t;

  localparam logic [15:0] DELAY_LAST  = REPEAT_DELAY - 16'd1;
  localparam logic [15:0] PERIOD_LAST = REPEAT_PERIOD - 16'd1;

  // Channel 0 is increase, channel 1 is decrease.
  logic [1:0]  raw;
  logic [1:0]  sync1;
  logic [1:0]  sync2;
  logic [1:0]  stable;
  logic [15:0] db_cnt    [2];
  state_t      state     [2];
  state_t      state_nxt [2];
  logic [15:0] rpt_cnt   [2];
  logic [15:0] rpt_nxt   [2];
  logic [1:0]  pulse;
  logic [1:0]  pulse_nxt;
  logic        both_held;

  assign raw = {btn_dec_raw, btn_inc_raw};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= '0;
      for (int unsigned i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else if (!ena) begin
      stable <= '0;
      for (int unsigned i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DEBOUNCE_CYCLES) begin
          stable[i] <= ~stable[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 16'd1;
        end
      end
    end
  end

  assign both_held = &stable;

  // While both levels are high every channel keeps its state but no pulse
  // fires and the repeat count stays at zero, so repeat restarts cleanly.
  always_comb begin
    pulse_nxt = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      state_nxt[i] = state[i];
      rpt_nxt[i]   = rpt_cnt[i];
      if (!stable[i]) begin
        state_nxt[i] = RELEASED;
        rpt_nxt[i]   = '0;
      end else begin
        case (state[i])
          RELEASED: begin
            state_nxt[i] = HELD_DELAY;
            rpt_nxt[i]   = '0;
            pulse_nxt[i] = ~both_held;
          end
          HELD_DELAY: begin
            if (both_held) begin
              rpt_nxt[i] = '0;
            end else if (REPEAT_DELAY != 16'd0) begin
              if (rpt_cnt[i] == DELAY_LAST) begin
                pulse_nxt[i] = 1'b1;
                state_nxt[i] = HELD_REPEAT;
                rpt_nxt[i]   = '0;
              end else begin
                rpt_nxt[i] = rpt_cnt[i] + 16'd1;
              end
            end
          end
          HELD_REPEAT: begin
            if (both_held) begin
              rpt_nxt[i] = '0;
            end else if (rpt_cnt[i] == PERIOD_LAST) begin
              pulse_nxt[i] = 1'b1;
              rpt_nxt[i]   = '0;
            end else begin
              rpt_nxt[i] = rpt_cnt[i] + 16'd1;
            end
          end
          default: begin
            state_nxt[i] = RELEASED;
            rpt_nxt[i]   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        state[i]   <= RELEASED;
        rpt_cnt[i] <= '0;
      end
    end else if (!ena) begin
      pulse <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        state[i]   <= RELEASED;
        rpt_cnt[i] <= '0;
      end
    end else begin
      pulse <= pulse_nxt;
      for (int unsigned i = 0; i < 2; i++) begin
        state[i]   <= state_nxt[i];
        rpt_cnt[i] <= rpt_nxt[i];
      end
    end
  end

  assign inc_pulse = pulse[0];
  assign dec_pulse = pulse[1];
  assign inc_level = stable[0];
  assign dec_level = stable[1];

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=8,
// REPEAT_PERIOD=4; a second instance has auto-repeat disabled.
module tb_button_conditioner;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b1;
  logic btn_inc_raw = 1'b0;
  logic btn_dec_raw = 1'b0;
  logic inc_pulse, dec_pulse, inc_level, dec_level;
  logic nr_inc_pulse, nr_dec_pulse, nr_inc_level, nr_dec_level;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  typedef struct {
    logic inc;
    logic dec;
    logic ip;
    logic dp;
    logic il;
    logic dl;
  } vec_t;

  vec_t tbl [40];

  always #5 clk = ~clk;

  button_conditioner #(
    .DEBOUNCE_CYCLES(16'd4),
    .REPEAT_DELAY   (16'd8),
    .REPEAT_PERIOD  (16'd4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .btn_inc_raw(btn_inc_raw),
    .btn_dec_raw(btn_dec_raw),
    .inc_pulse  (inc_pulse),
    .dec_pulse  (dec_pulse),
    .inc_level  (inc_level),
    .dec_level  (dec_level)
  );

  button_conditioner #(
    .DEBOUNCE_CYCLES(16'd4),
    .REPEAT_DELAY   (16'd0),
    .REPEAT_PERIOD  (16'd4)
  ) dut_nr (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .btn_inc_raw(btn_inc_raw),
    .btn_dec_raw(btn_dec_raw),
    .inc_pulse  (nr_inc_pulse),
    .dec_pulse  (nr_dec_pulse),
    .inc_level  (nr_inc_level),
    .dec_level  (nr_dec_level)
  );

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Drive inputs for clock edge k, then compare the main instance just after it.
  task automatic cyc(input string tag, input int k, input logic i, input logic d,
                     input logic e, input logic r, input logic eip, input logic edp,
                     input logic eil, input logic edl);
    @(negedge clk);
    btn_inc_raw = i;
    btn_dec_raw = d;
    ena = e;
    if (rst_n && !r) begin
      rst_n = 1'b0;
      #1;
      check($sformatf("%s[%0d] async_rst_outputs", tag, k),
            inc_pulse | dec_pulse | inc_level | dec_level, 1'b0);
    end else begin
      rst_n = r;
    end
    @(posedge clk);
    #1;
    check($sformatf("%s[%0d] inc_pulse", tag, k), inc_pulse, eip);
    check($sformatf("%s[%0d] dec_pulse", tag, k), dec_pulse, edp);
    check($sformatf("%s[%0d] inc_level", tag, k), inc_level, eil);
    check($sformatf("%s[%0d] dec_level", tag, k), dec_level, edl);
    check($sformatf("%s[%0d] exclusive", tag, k), inc_pulse & dec_pulse, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      btn_inc_raw = 1'b0;
      btn_dec_raw = 1'b0;
      ena = 1'b1;
      rst_n = 1'b1;
    end
  endtask

  initial begin
    // Single press held 20 cycles (repeats at 15, 19, 23, none on release),
    // followed by a 3-cycle decrease glitch that must leave everything at 0.
    for (int k = 0; k < 40; k++) begin
      tbl[k].inc = (k < 20);
      tbl[k].dec = (k >= 30 && k < 33);
      tbl[k].ip  = (k == 7 || k == 15 || k == 19 || k == 23);
      tbl[k].dp  = 1'b0;
      tbl[k].il  = (k >= 6 && k < 26);
      tbl[k].dl  = 1'b0;
    end

    repeat (2) @(posedge clk);
    #1;
    check("reset inc_pulse", inc_pulse, 1'b0);
    check("reset dec_pulse", dec_pulse, 1'b0);
    check("reset inc_level", inc_level, 1'b0);
    check("reset dec_level", dec_level, 1'b0);
    check("reset nr_inc_pulse", nr_inc_pulse, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 40; k++)
      cyc("press_glitch", k, tbl[k].inc, tbl[k].dec, 1'b1, 1'b1,
          tbl[k].ip, tbl[k].dp, tbl[k].il, tbl[k].dl);
    idle(4);

    // Both held together: pulses stop once both levels are high.
    for (int k = 0; k < 45; k++)
      cyc("both", k, k < 30, k >= 10 && k < 30, 1'b1, 1'b1,
          k == 7 || k == 15, 1'b0, k >= 6 && k < 36, k >= 16 && k < 36);
    idle(4);

    // Decrease released while increase stays held: repeat restarts from 0.
    for (int k = 0; k < 36; k++)
      cyc("resume", k, 1'b1, k >= 10 && k < 20, 1'b1, 1'b1,
          k == 7 || k == 15 || k == 30 || k == 34, 1'b0, k >= 6, k >= 16 && k < 26);
    idle(14);

    // Auto-repeat disabled on the second instance: exactly one pulse.
    for (int k = 0; k < 40; k++) begin
      cyc("norepeat_main", k, 1'b1, 1'b0, 1'b1, 1'b1,
          k == 7 || (k >= 15 && (k - 15) % 4 == 0), 1'b0, k >= 6, 1'b0);
      check($sformatf("norepeat[%0d] inc_pulse", k), nr_inc_pulse, k == 7);
      check($sformatf("norepeat[%0d] inc_level", k), nr_inc_level, k >= 6);
      check($sformatf("norepeat[%0d] dec_pulse", k), nr_dec_pulse, 1'b0);
      check($sformatf("norepeat[%0d] dec_level", k), nr_dec_level, 1'b0);
    end
    idle(14);

    // Enable dropped for edges 10..14 during a hold; synchronizers stay primed.
    for (int k = 0; k < 39; k++)
      cyc("enable", k, 1'b1, 1'b0, !(k >= 10 && k < 15), 1'b1,
          k == 7 || k == 20 || k == 28 || k == 32 || k == 36, 1'b0,
          (k >= 6 && k < 10) || k >= 19, 1'b0);
    idle(14);

    // Reset asserted for edges 12..13 during a hold; fresh press timing after.
    for (int k = 0; k < 35; k++)
      cyc("reset_hold", k, 1'b1, 1'b0, 1'b1, !(k == 12 || k == 13),
          k == 7 || k == 21 || k == 29 || k == 33, 1'b0,
          (k >= 6 && k < 12) || k >= 20, 1'b0);
    idle(14);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
